// File: rtl/cache_line_fill.sv
// Critical-word-first line refill: steers a 4-beat memory stream into line slots,
// forwards the first beat early, and hands the finished line over with valid/ready.
module cache_line_fill #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_offset,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic [WIDTH-1:0]   mem_data,
  output logic               crit_valid,
  output logic [WIDTH-1:0]   crit_data,
  output logic               line_valid,
  input  logic               line_ready,
  output logic [4*WIDTH-1:0] line_data,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [1:0]              base_q, base_d;
  logic                    crit_valid_q, crit_valid_d;
  logic [WIDTH-1:0]        crit_data_q, crit_data_d;
  logic [3:0][WIDTH-1:0]   line_q, line_d;
  logic [1:0]              slot;

  // Slot index wraps naturally in 2 bits, giving critical-word-first order.
  assign slot = base_q + cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      base_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      line_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      line_q       <= line_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    base_d       = base_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    line_d       = line_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_offset;
          cnt_d   = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (mem_valid) begin
          line_d[slot] = mem_data;
          cnt_d        = cnt_q + 2'd1;
          if (cnt_q == 2'd0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = mem_data;
          end
          if (cnt_q == 2'd3) state_d = DONE;
        end
      end
      DONE: begin
        if (line_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_ready  = (state_q == FILL);
  assign line_valid = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign line_data  = line_q;

endmodule

// File: doc/cache_line_fill.md
Name: cache_line_fill

Overview:
- Refill-side counterpart of the cache's word-select multiplexers.
- Takes a serial stream of words from memory and steers each one into its slot of a 4-word line. Fill order is critical-word-first with wrap-around.
- Forwards the critical word to the CPU early.
- Presents the assembled line to the cache data array through a valid/ready handshake.

Parameters:
- WIDTH, 32, data word width in bits; line is fixed at 4 words, so the word offset is 2 bits.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  fill request from the cache controller.
- req_ready  output  1  block idle, can accept a request.
- req_offset  input  2  word offset of the critical (missed) word.
- mem_valid  input  1  memory word available.
- mem_ready  output  1  block accepts a memory word.
- mem_data  input  WIDTH  memory word.
- crit_valid  output  1  one-cycle pulse: critical word available.
- crit_data  output  WIDTH  critical word; held until the next critical word.
- line_valid  output  1  assembled line available.
- line_ready  input  1  cache array accepts the line.
- line_data  output  4*WIDTH  line; word i occupies bits [i*WIDTH +: WIDTH].
- busy  output  1  high in FILL or DONE.

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is synchronous and active-low.
  - When rst_n=0 at a rising edge: state=IDLE, cnt=0, base=0, crit_valid=0, crit_data=0, line_valid=0, line buffer=0.
  - Outputs after reset: req_ready=1, mem_ready=0, busy=0.
- State machine, 3 states: IDLE, FILL, DONE.
- Combinational outputs:
  - req_ready = (state==IDLE).
  - mem_ready = (state==FILL).
  - line_valid = (state==DONE).
  - busy = !(state==IDLE).
- A transfer occurs on any channel only when valid and ready are both 1 at a rising edge.
- IDLE:
  - On req handshake: base<=req_offset, cnt<=0, next FILL.
  - mem_valid is ignored; no word is consumed.
- FILL:
  - Each mem handshake writes mem_data into slot (base+cnt) mod 4 (2-bit wrap), then cnt<=cnt+1.
  - When cnt==0 is accepted: crit_data<=mem_data and crit_valid=1 for exactly the next cycle.
  - When cnt==3 is accepted: next DONE.
  - Stalls with mem_valid=0 hold all state.
  - req_valid is ignored (req_ready=0).
- DONE:
  - line_data stable.
  - On line handshake: next IDLE.
  - line_ready=0 holds DONE indefinitely; no new request is accepted.
- Latency:
  - req accepted at edge T0; memory words can be accepted at T1..T4.
  - crit_valid high in cycle T1..T2; line_valid high from T4.
  - Line handshake at the earliest edge T5 gives req_ready=1 again after T5, so the next request can be accepted at T6.
  - Minimum request-to-request spacing is 6 cycles.
- line buffer:
  - Not cleared between fills; every slot is overwritten in each fill.
  - line_data is undefined to the consumer outside DONE, but must equal register contents.
- Reset mid-operation (FILL or DONE): abort, return to IDLE; the partial line is discarded and the buffer is zeroed.
- Simultaneous events:
  - line_ready high while in FILL has no effect.
  - A mem_valid pulse in the same cycle as the final-state transition is governed only by mem_ready.

Test Plan:
1. Reset → req_ready=1, mem_ready=0, line_valid=0, crit_valid=0, busy=0, line_data=0.
2. req_offset=0; words 0xA0,0xA1,0xA2,0xA3 streamed back-to-back, line_ready=1:
   - crit_valid pulses once with crit_data=0xA0.
   - line_data={0xA3,0xA2,0xA1,0xA0} (word3..word0).
   - line_valid high exactly 1 cycle.
   - req_ready returns 1 cycle later.
3. Wrap-around: req_offset=2; words 0xB0,0xB1,0xB2,0xB3 → line_data={0xB1,0xB0,0xB3,0xB2} (word3..word0); crit_data=0xB0.
4. Backpressure:
   - mem_valid toggling 1,0,0,1,1,0,1 → exactly 4 words captured in order, slot mapping correct.
   - Then line_ready=0 for 5 cycles → line_valid and line_data held stable, req_valid=1 not accepted.
5. Reset mid-fill: req_offset=1, 2 words accepted, rst_n=0 for 1 cycle → IDLE, line_data=0, no line_valid. A new fill with req_offset=3 then completes correctly.
6. Ignored inputs: req_valid held high throughout a fill → only one request consumed. mem_valid high in IDLE → mem_ready=0, no slot written.
